pixel_tx_buffer: RTL and testbench
==================================

PIXEL_TX_BUFFER -- requirements
Module: pixel_tx_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning pixel byte width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 2..256).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  DATA_W  transformed pixel byte from the transform stage.
REQ-006 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  buffer accepts a byte this cycle.
REQ-008 SHALL have port tx_data  output  DATA_W  byte presented to the UART transmitter.
REQ-009 SHALL have port tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
REQ-010 SHALL have port tx_busy  input  1  transmitter busy flag.
REQ-011 SHALL have port level  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port overflow  output  1  sticky flag: a byte was offered while full.

Function
REQ-013 SHALL drive in_ready = not full, combinationally from registered occupancy.
REQ-014 SHALL write in_data when in_valid and in_ready are both high at a clock edge.
REQ-015 SHALL not write when full, even if a pop occurs in the same cycle; the offered byte is dropped.
REQ-016 SHALL set overflow when in_valid is high and the buffer is full; it clears only on reset.
REQ-017 SHALL support a simultaneous push and pop when not full, leaving level unchanged.
REQ-018 SHALL wrap read and write pointers modulo DEPTH, with no gap or duplicate at wrap.
REQ-019 SHALL run a drain FSM with states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-020 In IDLE with level>0, SHALL pop the head into the registered tx_data and go to START.
REQ-021 In START, SHALL assert tx_start for exactly one cycle and go to WAIT_BUSY.
REQ-022 In WAIT_BUSY, SHALL go to WAIT_DONE when tx_busy=1.
REQ-023 SHALL leave WAIT_BUSY for WAIT_DONE after 16 cycles without tx_busy, so a missed busy cannot deadlock the FSM.
REQ-024 In WAIT_DONE, SHALL go to IDLE when tx_busy=0.
REQ-025 SHALL hold tx_data stable from START until the FSM returns to IDLE.
REQ-026 SHALL give a latency of two cycles: a byte written into an empty buffer at edge N produces tx_start high in the cycle after edge N+2.
REQ-027 SHALL emit bytes in strict arrival order, one tx_start per accepted byte.

Reset
REQ-028 On reset, SHALL drive state=IDLE, pointers=0, level=0, tx_data=0, tx_start=0 and overflow=0 immediately, independent of clk.
REQ-029 SHALL discard all buffered bytes and any in-flight byte on reset mid-transmission; no tx_start follows until a new byte is written.
REQ-030 SHALL drive in_ready=1 during and after reset.

Structure
REQ-031 SHALL place DATA_W and DEPTH defaults, the FSM state encoding, and the WAIT_BUSY timeout constant (16) in the shared package pixel_pkg.
REQ-032 SHALL implement storage as one sub-module, sync_fifo (push, pop, full, empty, level), with the drain FSM in pixel_tx_buffer.

Verification
REQ-033 SHALL verify single byte: write 0x32 into an empty buffer -> tx_start high 2 cycles later with tx_data=0x32; FSM back in IDLE after tx_busy falls.
REQ-034 SHALL verify order and wrap: write 40 bytes 0x00..0x27 with tx_busy modeled as 10 cycles per byte -> transmitter receives 0x00..0x27 in order with no loss and in_valid throttled by in_ready.
REQ-035 SHALL verify full: with tx_busy held high, write 17 bytes -> level=16, in_ready=0, overflow=1, and byte 17 is never transmitted.
REQ-036 SHALL verify busy timeout: tx_busy held 0 after tx_start -> FSM reaches WAIT_DONE after 16 cycles, then IDLE, and the next byte is started.
REQ-037 SHALL verify reset mid-operation: assert reset in WAIT_DONE with level=5 -> level=0, tx_start=0 and overflow=0 immediately; no tx_start until a new write.
REQ-038 SHALL verify simultaneous push and pop: with level=3, a push on the same cycle as the IDLE pop -> level stays 3 and data stays in order.

Source files
------------

// File: rtl/pixel_pkg.sv
// pixel_pkg: shared constants and types for the pixel transmit buffer.
//   DATA_W_DEF    default pixel byte width
//   DEPTH_DEF     default FIFO depth (power of two)
//   BUSY_TIMEOUT  cycles the drain FSM waits for tx_busy before moving on
//   drain_state_t drain FSM state encoding
package pixel_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int DEPTH_DEF    = 16;
  localparam int BUSY_TIMEOUT = 16;
  localparam int TIMEOUT_W    = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO holding pixel bytes for the drain FSM.
//   clk, reset   clock and asynchronous active-high reset
//   push, wdata  write request and byte (ignored while full)
//   pop, rdata   read request and head-of-queue byte (ignored while empty)
//   full, empty  occupancy flags derived from the registered level
//   level        number of stored bytes, 0..DEPTH
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wptr_r;
  logic [AW-1:0]     rptr_r;
  logic [LW-1:0]     level_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (level_r == LW'(DEPTH));
  assign empty     = (level_r == {LW{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_r[rptr_r];
  assign level     = level_r;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r <= {AW{1'b0}};
      rptr_r <= {AW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_r <= {LW{1'b0}};
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/pixel_tx_buffer.sv
// pixel_tx_buffer: buffers transformed pixel bytes and feeds them one at a
// time to a UART transmitter.
//   clk, reset          clock and asynchronous active-high reset
//   in_data, in_valid   byte from the transform stage
//   in_ready            buffer not full (depends only on registered occupancy)
//   tx_data, tx_start   registered byte and one-cycle start pulse to the UART
//   tx_busy             transmitter busy flag
//   level               current FIFO occupancy
//   overflow            sticky: a byte was offered while the buffer was full
module pixel_tx_buffer
  import pixel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  drain_state_t          state_r;
  drain_state_t          state_nxt_s;
  logic [DATA_W-1:0]     tx_data_r;
  logic [DATA_W-1:0]     tx_data_nxt_s;
  logic                  tx_start_r;
  logic                  tx_start_nxt_s;
  logic [TIMEOUT_W-1:0]  wait_cnt_r;
  logic [TIMEOUT_W-1:0]  wait_cnt_nxt_s;
  logic                  overflow_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_W-1:0]     head_s;
  logic [LVL_W-1:0]      level_s;

  // A pop in the same cycle does not free a slot for the incoming byte.
  assign in_ready = ~full_s;
  assign push_s   = in_valid & ~full_s;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata (in_data),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level_s)
  );

  assign tx_data  = tx_data_r;
  assign tx_start = tx_start_r;
  assign overflow = overflow_r;
  assign level    = level_s;

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (in_valid && full_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Drain FSM state and its registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      tx_data_r  <= {DATA_W{1'b0}};
      tx_start_r <= 1'b0;
      wait_cnt_r <= {TIMEOUT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
      tx_start_r <= tx_start_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Drain FSM next state. tx_start is registered, so the pulse computed in
  // START appears one cycle later, while the FSM already sits in WAIT_BUSY.
  always_comb begin
    state_nxt_s    = state_r;
    tx_data_nxt_s  = tx_data_r;
    tx_start_nxt_s = 1'b0;
    wait_cnt_nxt_s = wait_cnt_r;
    pop_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s         = 1'b1;
          tx_data_nxt_s = head_s;
          state_nxt_s   = START;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      START: begin
        tx_start_nxt_s = 1'b1;
        wait_cnt_nxt_s = {TIMEOUT_W{1'b0}};
        state_nxt_s    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Give up on seeing busy after the timeout so a missed flag
        // cannot stall the drain forever.
        if (tx_busy) begin
          state_nxt_s = WAIT_DONE;
        end else if (wait_cnt_r == TIMEOUT_W'(BUSY_TIMEOUT - 1)) begin
          state_nxt_s = WAIT_DONE;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + TIMEOUT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pixel_tx_buffer.sv
module tb_pixel_tx_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [4:0] level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // scoreboard of bytes accepted by the buffer, in arrival order
  logic [7:0] exp_q[$];

  // transmitter model state
  int cyc_n          = 0;
  int n_start        = 0;
  int prev_start_cyc = 0;
  int last_start_cyc = 0;
  int busy_len       = 0;
  int busy_cnt       = 0;
  bit force_busy     = 1'b0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    int         lvl;
    logic       st;
  } vec_t;
  vec_t tbl[16];

  pixel_tx_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .level    (level),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance past the edge, then act as the UART transmitter.
  task automatic tick();
    logic [7:0] exp_b;
    @(posedge clk);
    #1;
    cyc_n++;
    if (tx_start) begin
      n_start++;
      prev_start_cyc = last_start_cyc;
      last_start_cyc = cyc_n;
      check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(exp_b));
      end
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = force_busy || (busy_cnt > 0);
  endtask

  // Drive the next edge's input; record the byte if the buffer will take it.
  task automatic drive(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    if (v && in_ready) exp_q.push_back(d);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (24) tick();
  endtask

  initial begin
    int i;
    int n0;
    int guard;
    int wcyc;

    // single byte then push-while-pop at level 3 (busy lasts 3 cycles)
    tbl[0]  = '{1'b1, 8'h32, 1'b1, 0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0};
    tbl[3]  = '{1'b1, 8'h41, 1'b1, 0, 1'b1};
    tbl[4]  = '{1'b1, 8'h42, 1'b1, 1, 1'b0};
    tbl[5]  = '{1'b1, 8'h43, 1'b1, 2, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 3, 1'b0};
    tbl[7]  = '{1'b1, 8'h44, 1'b1, 3, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 3, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 3, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 3, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 3, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 3, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 3, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 2, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 2, 1'b1};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tx_busy  = 1'b0;
    #2;
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    repeat (3) tick();
    @(negedge clk);
    reset = 1'b0;

    // table-driven cycle-exact sequence
    busy_len = 3;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("tbl_level", 32'(level), 32'(tbl[k].lvl));
      check("tbl_ready", 32'(in_ready), 32'(tbl[k].rdy));
      check("tbl_start", 32'(tx_start), 32'(tbl[k].st));
      drive(tbl[k].v, tbl[k].d);
    end
    wait_drain(200);

    // order and wrap: 40 bytes, 10-cycle busy, offered only when ready
    busy_len = 10;
    n0 = n_start;
    i = 0;
    guard = 0;
    while (i < 40 && guard < 3000) begin
      tick();
      if (in_ready) begin
        drive(1'b1, 8'(i));
        i++;
      end else begin
        drive(1'b0, 8'h00);
      end
      guard++;
    end
    tick();
    drive(1'b0, 8'h00);
    check("wrap_offered", 32'(i), 32'd40);
    wait_drain(1000);
    check("wrap_starts", 32'(n_start - n0), 32'd40);
    check("wrap_level", 32'(level), 32'd0);
    check("wrap_overflow", 32'(overflow), 32'd0);

    // full: FSM parked in WAIT_DONE, then 17 bytes offered back to back
    force_busy = 1'b1;
    busy_len = 2;
    n0 = n_start;
    tick(); drive(1'b1, 8'h80);
    tick(); drive(1'b0, 8'h00);
    guard = 0;
    while (n_start == n0 && guard < 20) begin
      tick();
      guard++;
    end
    check("full_lead_start", 32'(n_start - n0), 32'd1);
    for (int j = 0; j < 17; j++) begin
      tick();
      drive(1'b1, 8'h90 + 8'(j));
    end
    tick();
    drive(1'b0, 8'h00);
    check("full_level", 32'(level), 32'd16);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_queued", 32'(exp_q.size()), 32'd16);
    force_busy = 1'b0;
    wait_drain(600);
    check("full_starts", 32'(n_start - n0), 32'd17);
    check("full_overflow_sticky", 32'(overflow), 32'd1);

    // busy timeout: transmitter never raises busy
    busy_len = 0;
    n0 = n_start;
    tick(); drive(1'b1, 8'h61); wcyc = cyc_n;
    tick(); drive(1'b1, 8'h62);
    tick(); drive(1'b0, 8'h00);
    guard = 0;
    while (n_start < n0 + 2 && guard < 80) begin
      tick();
      guard++;
    end
    check("to_starts", 32'(n_start - n0), 32'd2);
    check("to_latency", 32'(prev_start_cyc - (wcyc + 1)), 32'd2);
    check("to_gap", 32'(last_start_cyc - prev_start_cyc), 32'd19);
    repeat (24) tick();

    // reset in WAIT_DONE with 5 bytes queued
    force_busy = 1'b1;
    busy_len = 2;
    n0 = n_start;
    tick(); drive(1'b1, 8'hB0);
    tick(); drive(1'b0, 8'h00);
    guard = 0;
    while (n_start == n0 && guard < 20) begin
      tick();
      guard++;
    end
    for (int j = 0; j < 5; j++) begin
      tick();
      drive(1'b1, 8'hC0 + 8'(j));
    end
    tick();
    drive(1'b0, 8'h00);
    check("mid_level_pre", 32'(level), 32'd5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_level", 32'(level), 32'd0);
    check("mid_start", 32'(tx_start), 32'd0);
    check("mid_overflow", 32'(overflow), 32'd0);
    check("mid_ready", 32'(in_ready), 32'd1);
    check("mid_txdata", 32'(tx_data), 32'd0);
    exp_q.delete();
    force_busy = 1'b0;
    busy_cnt = 0;
    tx_busy = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b0;
    n0 = n_start;
    repeat (30) tick();
    check("mid_no_start", 32'(n_start - n0), 32'd0);
    tick(); drive(1'b1, 8'h5A);
    tick(); drive(1'b0, 8'h00);
    wait_drain(100);
    check("mid_new_start", 32'(n_start - n0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
